imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a stream of 32-bit instruction words on a valid/ready interface and writes them into consecutive instruction-memory locations through the memory's write port (`wea`/`addra`/`dina`). It holds the processor in reset until the image is fully written, then releases it.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: streams words into consecutive IMEM locations and holds the CPU in reset until done.
// Optional checksum beat enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int size     = 32,
    parameter int MemSize  = 512,
    parameter int CntWidth = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [CntWidth-1:0] base_addr,
    input  logic [CntWidth-1:0] word_count,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                wea,
    output logic [size-1:0]     addra,
    output logic [31:0]         dina,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CntWidth:0] MEM_LIMIT = (CntWidth+1)'(MemSize);

    state_t              state_q, state_d;
    logic [CntWidth-1:0] ptr_q, ptr_d;
    logic [CntWidth-1:0] rem_q, rem_d;
    logic                in_ready_q, in_ready_d;
    logic                wea_q, wea_d;
    logic [size-1:0]     addra_q, addra_d;
    logic [31:0]         dina_q, dina_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    logic [CntWidth:0]   end_addr;
    logic                range_bad;
    logic                beat;

    assign end_addr  = {1'b0, base_addr} + {1'b0, word_count};
    assign range_bad = (word_count == '0) || (end_addr > MEM_LIMIT);
    assign beat      = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            in_ready_q <= in_ready_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (range_bad) begin
                        state_d = S_ERR;
                    end else begin
                        ptr_d   = base_addr;
                        rem_d   = word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    // remaining==0 while still in LOAD marks the checksum beat
                    if (rem_q == '0) begin
                        state_d = ((sum_q + in_data) == '0) ? S_FLUSH : S_ERR;
                    end else begin
                        wea_d   = 1'b1;
                        addra_d = '0;
                        addra_d[CntWidth-1:0] = ptr_q;
                        dina_d  = in_data;
                        sum_d   = sum_q + in_data;
                        ptr_d   = ptr_q + CntWidth'(1);
                        rem_d   = rem_q - CntWidth'(1);
                    end
`else
                    wea_d   = 1'b1;
                    addra_d = '0;
                    addra_d[CntWidth-1:0] = ptr_q;
                    dina_d  = in_data;
                    ptr_d   = ptr_q + CntWidth'(1);
                    rem_d   = rem_q - CntWidth'(1);
                    if (rem_q == CntWidth'(1)) begin
                        state_d = S_FLUSH;
                    end
`endif
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_comb begin
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_FLUSH);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    assign in_ready = in_ready_q;
    assign wea      = wea_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected memory writes, a monitor checks every wea cycle.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  word_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] stim [0:7];
    logic [31:0] mem  [0:511];
    logic [31:0] snap [0:5];

    imem_loader #(.size(32), .MemSize(512), .CntWidth(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (wea) mem[addra[8:0]] <= dina;
    end

    // Monitor: every write presented on the memory port must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && wea) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", addra, dina);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({addra, dina} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             addra, dina, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic check_status(input string name, input logic b, input logic d,
                                input logic e, input logic h, input logic r);
        check({name, "_busy"},     32'(busy),     32'(b));
        check({name, "_done"},     32'(done),     32'(d));
        check({name, "_error"},    32'(error),    32'(e));
        check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        check({name, "_in_ready"}, 32'(in_ready), 32'(r));
    endtask

    task automatic do_start(input logic [9:0] base, input logic [9:0] cnt);
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives n_beats words from stim[]; only the first n_write of them are expected in memory.
    task automatic stream(input int n_beats, input int n_write, input logic [9:0] base, input bit gapped);
        int  idx = 0;
        int  cyc = 0;
        bit  v;
        bit  acc;
        while (idx < n_beats && cyc < 200) begin
            v        = gapped ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_data  = v ? stim[idx] : (32'hBAD00000 | 32'(cyc));
            acc      = v && in_ready;
            if (acc && idx < n_write) exp_q.push_back({32'(base) + 32'(idx), stim[idx]});
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < n_beats) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d beats accepted, required %0d", idx, n_beats);
        end
    endtask

    task automatic check_completion(input string name);
        check_status({name, "_flush"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_status({name, "_done"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_wea",   32'(wea), 32'h0);
        check("reset_addra", addra,    32'h0);
        check("reset_dina",  dina,     32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Zero-length load is rejected.
        do_start(10'd0, 10'd0);
        check_status("zero_count", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_status("zero_count_hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Back-to-back load of four words.
        stim[0] = 32'h11111111; stim[1] = 32'h22222222;
        stim[2] = 32'h33333333; stim[3] = 32'h44444444;
        do_start(10'd0, 10'd4);
        check_status("b2b_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        stream(4, 4, 10'd0, 1'b0);
        check_completion("b2b");

        // Gapped stream filling the top of memory.
        stim[0] = 32'hA5080000; stim[1] = 32'hA5090001;
        stim[2] = 32'hA5100002; stim[3] = 32'hA5110003;
        do_start(10'd508, 10'd4);
        stream(4, 4, 10'd508, 1'b1);
        check_completion("gapped");
        check("gapped_mem511", mem[511], 32'hA5110003);

        // 509 + 4 = 513 exceeds the memory depth.
        do_start(10'd509, 10'd4);
        check_status("overrange", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset after two of six beats.
        for (int i = 0; i < 6; i++) snap[i] = mem[i];
        for (int i = 0; i < 6; i++) stim[i] = 32'hC0DE0000 + 32'(i);
        do_start(10'd0, 10'd6);
        stream(2, 2, 10'd0, 1'b0);
        @(posedge clk); #1;
        check_status("midload", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check_status("midreset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("midreset_wea",   32'(wea), 32'h0);
        check("midreset_addra", addra,    32'h0);
        check("midreset_dina",  dina,     32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midreset_mem0", mem[0], 32'hC0DE0000);
        check("midreset_mem1", mem[1], 32'hC0DE0001);
        for (int i = 2; i < 6; i++) check($sformatf("midreset_mem%0d", i), mem[i], snap[i]);
        @(posedge clk); #1;

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim[0] = 32'h00000005; stim[1] = 32'h00000003; stim[2] = 32'hFFFFFFF8;
        do_start(10'd100, 10'd2);
        stream(3, 2, 10'd100, 1'b0);
        check_completion("csum_ok");

        stim[2] = 32'hFFFFFFF9;
        do_start(10'd100, 10'd2);
        stream(3, 2, 10'd100, 1'b0);
        check_status("csum_bad", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
